// File: rtl/uart_alu_ctrl_pkg.sv
// Shared constants for the UART-driven ALU controller: state encoding,
// default widths and the ALU opcode map used by the external ALU.
package uart_alu_ctrl_pkg;

   localparam int NB_DATA_DEF = 8;
   localparam int NB_OP_DEF   = 6;
   localparam int NB_STATE    = 3;

   localparam logic [NB_STATE-1:0] ST_GET_A  = 3'd0;
   localparam logic [NB_STATE-1:0] ST_GET_B  = 3'd1;
   localparam logic [NB_STATE-1:0] ST_GET_OP = 3'd2;
   localparam logic [NB_STATE-1:0] ST_EXEC   = 3'd3;
   localparam logic [NB_STATE-1:0] ST_SEND   = 3'd4;

   localparam logic [5:0] OP_ADD = 6'h20;
   localparam logic [5:0] OP_SUB = 6'h22;
   localparam logic [5:0] OP_AND = 6'h24;
   localparam logic [5:0] OP_OR  = 6'h25;
   localparam logic [5:0] OP_XOR = 6'h26;
   localparam logic [5:0] OP_NOR = 6'h27;
   localparam logic [5:0] OP_SRA = 6'h03;
   localparam logic [5:0] OP_SRL = 6'h02;

endpackage

// File: rtl/uart_alu_ctrl_frame_timer.sv
// Inter-byte timeout counter. Counts enabled cycles since the last clear
// and flags expiry at TIMEOUT_CYC-1; it holds there rather than wrapping.
module frame_timer #(
   parameter int TIMEOUT_CYC = 1_000_000,
   parameter int NB_TMO      = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [NB_TMO-1:0] TC_LAST = NB_TMO'(TIMEOUT_CYC - 1);

   logic [NB_TMO-1:0] count;

   // Saturating up-counter; clear has priority over counting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == TC_LAST);

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frame controller between a UART FIFO pair and an external ALU.
// Collects A, B and opcode bytes, runs one ALU cycle and sends the result.
//
// state     | meaning
// ----------+------------------------------------------------------
// GET_A     | idle, waiting for first operand byte
// GET_B     | waiting for second operand byte (timeout armed)
// GET_OP    | waiting for opcode byte (timeout armed)
// EXEC      | one cycle, register ALU result
// SEND      | push result to TX FIFO once it has room
module uart_alu_ctrl
   import uart_alu_ctrl_pkg::*;
#(
   parameter int NB_DATA     = NB_DATA_DEF,
   parameter int NB_OP       = NB_OP_DEF,
   parameter int TIMEOUT_CYC = 1_000_000,
   parameter int NB_TMO      = 20
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_rx_empty,
   input  logic [NB_DATA-1:0] i_r_data,
   output logic               o_rd_uart,
   input  logic               i_tx_full,
   output logic               o_wr_uart,
   output logic [NB_DATA-1:0] o_w_data,
   output logic [NB_DATA-1:0] o_data_a,
   output logic [NB_DATA-1:0] o_data_b,
   output logic [NB_OP-1:0]   o_opcode,
   input  logic [NB_DATA-1:0] i_alu_result,
   output logic               o_frame_err,
   output logic               o_busy
);

   logic [NB_STATE-1:0] state;
   logic [NB_STATE-1:0] state_nxt;
   logic [NB_DATA-1:0]  a_stage;
   logic [NB_DATA-1:0]  b_stage;
   logic [NB_DATA-1:0]  data_a;
   logic [NB_DATA-1:0]  data_b;
   logic [NB_OP-1:0]    opcode;
   logic [NB_DATA-1:0]  result;
   logic                collecting;
   logic                waiting;
   logic                pop;
   logic                tmo_expired;
   logic                timeout;

   assign collecting = (state == ST_GET_A) || (state == ST_GET_B) || (state == ST_GET_OP);
   assign waiting    = (state == ST_GET_B) || (state == ST_GET_OP);
   // Pop is gated by reset so the FIFO is never drained while held in reset.
   assign pop        = collecting && !i_rx_empty && !i_reset;
   // A byte present in the expiry cycle wins over the timeout.
   assign timeout    = waiting && i_rx_empty && tmo_expired;

   frame_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .NB_TMO      (NB_TMO)
   ) u_frame_timer (
      .clk     (i_clk),
      .rst     (i_reset),
      .clear   (pop || !waiting),
      .enable  (waiting && i_rx_empty),
      .expired (tmo_expired)
   );

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_GET_A:  if (pop) state_nxt = ST_GET_B;
         ST_GET_B:  if (pop) state_nxt = ST_GET_OP;
                    else if (timeout) state_nxt = ST_GET_A;
         ST_GET_OP: if (pop) state_nxt = ST_EXEC;
                    else if (timeout) state_nxt = ST_GET_A;
         ST_EXEC:   state_nxt = ST_SEND;
         ST_SEND:   if (!i_tx_full) state_nxt = ST_GET_A;
         default:   state_nxt = ST_GET_A;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) state <= ST_GET_A;
      else         state <= state_nxt;
   end

   // Operand capture: A and B are staged and only published together with
   // the opcode, so an abandoned frame never disturbs the ALU operands.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         a_stage <= '0;
         b_stage <= '0;
         data_a  <= '0;
         data_b  <= '0;
         opcode  <= '0;
         result  <= '0;
      end else begin
         if (pop && (state == ST_GET_A)) a_stage <= i_r_data;
         if (pop && (state == ST_GET_B)) b_stage <= i_r_data;
         if (pop && (state == ST_GET_OP)) begin
            data_a <= a_stage;
            data_b <= b_stage;
            opcode <= i_r_data[NB_OP-1:0];
         end
         if (state == ST_EXEC) result <= i_alu_result;
      end
   end

   assign o_rd_uart   = pop;
   assign o_wr_uart   = (state == ST_SEND) && !i_tx_full;
   assign o_w_data    = result;
   assign o_data_a    = data_a;
   assign o_data_b    = data_b;
   assign o_opcode    = opcode;
   assign o_frame_err = timeout;
   assign o_busy      = (state != ST_GET_A);

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: RX FIFO as a queue, ALU stub computing A+B,
// and a frame-level reference model compared on every falling edge.
module tb_uart_alu_ctrl;
   import uart_alu_ctrl_pkg::*;

   localparam int NB_DATA = 8;
   localparam int NB_OP   = 6;
   localparam int TC      = 16;
   localparam int NB_TMO  = 5;

   logic               i_clk;
   logic               i_reset;
   logic               i_rx_empty;
   logic [NB_DATA-1:0] i_r_data;
   logic               o_rd_uart;
   logic               i_tx_full;
   logic               o_wr_uart;
   logic [NB_DATA-1:0] o_w_data;
   logic [NB_DATA-1:0] o_data_a;
   logic [NB_DATA-1:0] o_data_b;
   logic [NB_OP-1:0]   o_opcode;
   logic [NB_DATA-1:0] i_alu_result;
   logic               o_frame_err;
   logic               o_busy;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] rx_q[$];
   logic [7:0] wr_log[$];
   logic       pop_pend = 1'b0;

   // Reference model: phase 0 collecting (m_k bytes so far), 1 exec, 2 send
   int         m_phase = 0;
   int         m_k     = 0;
   int         m_idle  = 0;
   logic [7:0] m_a_stage = '0, m_b_stage = '0;
   logic [7:0] m_a = '0, m_b = '0, m_res = '0;
   logic [5:0] m_op = '0;

   int         cyc = 0, wr_cnt = 0, err_cnt = 0, pop3_cyc = 0, wr_cyc = 0;
   logic [7:0] last_wdata = '0;

   uart_alu_ctrl #(
      .NB_DATA     (NB_DATA),
      .NB_OP       (NB_OP),
      .TIMEOUT_CYC (TC),
      .NB_TMO      (NB_TMO)
   ) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_rx_empty   (i_rx_empty),
      .i_r_data     (i_r_data),
      .o_rd_uart    (o_rd_uart),
      .i_tx_full    (i_tx_full),
      .o_wr_uart    (o_wr_uart),
      .o_w_data     (o_w_data),
      .o_data_a     (o_data_a),
      .o_data_b     (o_data_b),
      .o_opcode     (o_opcode),
      .i_alu_result (i_alu_result),
      .o_frame_err  (o_frame_err),
      .o_busy       (o_busy)
   );

   assign i_alu_result = o_data_a + o_data_b;

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic refresh();
      i_rx_empty = (rx_q.size() == 0);
      i_r_data   = i_rx_empty ? 8'h00 : rx_q[0];
   endtask

   task automatic model_reset();
      m_phase = 0; m_k = 0; m_idle = 0;
      m_a_stage = '0; m_b_stage = '0;
      m_a = '0; m_b = '0; m_op = '0; m_res = '0;
   endtask

   // Per-cycle comparison against the model, then advance the model.
   always @(negedge i_clk) begin
      logic       exp_rd, exp_wr, exp_err, exp_busy;
      logic [7:0] b;
      cyc++;
      if (i_reset) model_reset();
      exp_rd   = (m_phase == 0) && !i_rx_empty && !i_reset;
      exp_wr   = (m_phase == 2) && !i_tx_full;
      exp_err  = (m_phase == 0) && (m_k > 0) && i_rx_empty && (m_idle == TC - 1);
      exp_busy = !((m_phase == 0) && (m_k == 0));
      check("rd_uart",   o_rd_uart,   exp_rd);
      check("wr_uart",   o_wr_uart,   exp_wr);
      check("frame_err", o_frame_err, exp_err);
      check("busy",      o_busy,      exp_busy);
      check("data_a",    o_data_a,    m_a);
      check("data_b",    o_data_b,    m_b);
      check("opcode",    o_opcode,    m_op);
      if (exp_wr) check("w_data", o_w_data, m_res);
      if (o_wr_uart) begin
         wr_cnt++; last_wdata = o_w_data; wr_cyc = cyc; wr_log.push_back(o_w_data);
      end
      if (o_frame_err) err_cnt++;
      pop_pend = o_rd_uart && !i_rx_empty;
      if (exp_rd) begin
         b = rx_q[0];
         m_idle = 0;
         if (m_k == 0) begin
            m_a_stage = b; m_k = 1;
         end else if (m_k == 1) begin
            m_b_stage = b; m_k = 2;
         end else begin
            m_a = m_a_stage; m_b = m_b_stage; m_op = b[5:0];
            m_res = m_a_stage + m_b_stage;
            m_k = 0; m_phase = 1; pop3_cyc = cyc;
         end
      end else if ((m_phase == 0) && (m_k > 0) && i_rx_empty) begin
         if (m_idle == TC - 1) begin
            m_k = 0; m_idle = 0;
         end else begin
            m_idle++;
         end
      end else if (m_phase == 1) begin
         m_phase = 2;
      end else if ((m_phase == 2) && !i_tx_full) begin
         m_phase = 0; m_k = 0;
      end
   end

   // RX FIFO: apply the pop strobe seen in the previous cycle.
   always @(posedge i_clk) begin
      #1;
      if (pop_pend && !i_reset) void'(rx_q.pop_front());
      pop_pend = 1'b0;
      refresh();
   end

   task automatic push_byte(input logic [7:0] b, input int gap);
      repeat (gap) @(posedge i_clk);
      @(posedge i_clk); #2;
      rx_q.push_back(b);
      refresh();
   endtask

   task automatic set_full(input logic v);
      @(posedge i_clk); #2;
      i_tx_full = v;
   endtask

   task automatic wait_wr(input int target, input string name);
      int n;
      n = 0;
      while (wr_cnt < target && n < 200) begin
         @(posedge i_clk); n++;
      end
      check({name, "_wr_count"}, wr_cnt, target);
   endtask

   initial begin
      int         e0, w0, n;
      logic       found;
      logic [7:0] ra, rb, rop;

      i_reset = 1'b1;
      i_tx_full = 1'b0;
      rx_q.push_back(8'h05);
      refresh();
      repeat (3) @(posedge i_clk);
      #1;
      check("rst_rd_uart", o_rd_uart, 1'b0);
      check("rst_wr_uart", o_wr_uart, 1'b0);
      check("rst_frame_err", o_frame_err, 1'b0);
      check("rst_busy", o_busy, 1'b0);
      check("rst_data_a", o_data_a, 8'h00);
      check("rst_w_data", o_w_data, 8'h00);
      @(posedge i_clk); #2;
      i_reset = 1'b0;

      // Basic frame 05 + 03
      push_byte(8'h03, 0);
      push_byte(8'h20, 0);
      wait_wr(1, "basic");
      check("basic_result", last_wdata, 8'h08);
      check("basic_opcode", o_opcode, 6'h20);
      check("basic_a", o_data_a, 8'h05);
      check("basic_b", o_data_b, 8'h03);
      check("basic_latency", wr_cyc - pop3_cyc, 2);

      // Opcode upper bits ignored
      push_byte(8'h07, 0);
      push_byte(8'h02, 1);
      push_byte(8'hA3, 2);
      wait_wr(2, "opmask");
      check("opmask_opcode", o_opcode, 6'h23);
      check("opmask_result", last_wdata, 8'h09);

      // Inter-byte timeout
      e0 = err_cnt;
      push_byte(8'h05, 0);
      push_byte(8'h03, 0);
      n = 0;
      while (err_cnt == e0 && n < 100) begin
         @(posedge i_clk); n++;
      end
      check("tmo_err_count", err_cnt, e0 + 1);
      repeat (2) @(posedge i_clk);
      #1;
      check("tmo_busy", o_busy, 1'b0);
      check("tmo_a_kept", o_data_a, 8'h07);
      check("tmo_b_kept", o_data_b, 8'h02);
      push_byte(8'h01, 0);
      push_byte(8'h01, 0);
      push_byte(8'h20, 0);
      wait_wr(3, "tmo_next");
      check("tmo_next_result", last_wdata, 8'h02);

      // Byte arrives in the expiry cycle: pop wins
      e0 = err_cnt;
      push_byte(8'h11, 0);
      push_byte(8'h22, 0);
      found = 1'b0;
      n = 0;
      while (!found && n < 60) begin
         @(posedge i_clk); n++;
         found = (m_phase == 0) && (m_k == 2) && (m_idle == TC - 1);
      end
      check("race_reached", found, 1'b1);
      #2;
      rx_q.push_back(8'h20);
      refresh();
      wait_wr(4, "race");
      check("race_no_err", err_cnt, e0);
      check("race_result", last_wdata, 8'h33);

      // TX full holds SEND
      set_full(1'b1);
      push_byte(8'h0A, 0);
      push_byte(8'h0B, 0);
      push_byte(8'h20, 0);
      n = 0;
      while (m_phase != 2 && n < 50) begin
         @(posedge i_clk); n++;
      end
      check("full_in_send", m_phase, 2);
      w0 = wr_cnt;
      repeat (50) begin
         @(posedge i_clk); #1;
         check("full_busy", o_busy, 1'b1);
      end
      check("full_no_write", wr_cnt, w0);
      set_full(1'b0);
      wait_wr(w0 + 1, "full_release");
      check("full_result", last_wdata, 8'h15);

      // Two frames preloaded back to back
      @(posedge i_clk); #2;
      rx_q.push_back(8'h02); rx_q.push_back(8'h03); rx_q.push_back(8'h20);
      rx_q.push_back(8'h10); rx_q.push_back(8'h20); rx_q.push_back(8'h22);
      refresh();
      wait_wr(w0 + 3, "b2b");
      check("b2b_first", wr_log[w0 + 1], 8'h05);
      check("b2b_second", wr_log[w0 + 2], 8'h30);

      // Reset mid-frame
      w0 = wr_cnt;
      push_byte(8'h33, 0);
      push_byte(8'h44, 0);
      n = 0;
      while (m_k != 2 && n < 50) begin
         @(posedge i_clk); n++;
      end
      #2;
      rx_q.push_back(8'h0F);
      refresh();
      #1;
      i_reset = 1'b1;
      #1;
      check("arst_rd_uart", o_rd_uart, 1'b0);
      check("arst_busy", o_busy, 1'b0);
      check("arst_data_a", o_data_a, 8'h00);
      check("arst_data_b", o_data_b, 8'h00);
      check("arst_opcode", o_opcode, 6'h00);
      check("arst_w_data", o_w_data, 8'h00);
      repeat (2) @(posedge i_clk);
      @(posedge i_clk); #2;
      i_reset = 1'b0;
      push_byte(8'hF0, 0);
      push_byte(8'h25, 0);
      wait_wr(w0 + 1, "post_rst");
      check("post_rst_result", last_wdata, 8'hFF);

      // Randomized frames
      for (int f = 0; f < 25; f++) begin
         w0 = wr_cnt;
         ra  = 8'($urandom_range(0, 255));
         rb  = 8'($urandom_range(0, 255));
         rop = 8'($urandom_range(0, 255));
         set_full($urandom_range(0, 2) == 0);
         push_byte(ra, $urandom_range(0, 4));
         push_byte(rb, $urandom_range(0, 4));
         push_byte(rop, $urandom_range(0, 4));
         repeat ($urandom_range(0, 10)) @(posedge i_clk);
         set_full(1'b0);
         wait_wr(w0 + 1, "rand");
         check("rand_result", last_wdata, 8'(ra + rb));
         check("rand_opcode", o_opcode, rop[5:0]);
      end

      repeat (5) @(posedge i_clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
